// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer (CPHA=0): TX FIFO -> MOSI, MISO -> RX FIFO, drives SCLK/SS_N.
// Define SPI_LSB_FIRST_EN for LSB-first bit order; MSB-first otherwise.
module spi_xfer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  EN,
    input  logic                  CPOL,
    input  logic [DIV_WIDTH-1:0]  CLKDIV,
    input  logic                  TXFIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_POP,
    input  logic                  RXFIFO_FULL,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  RX_PUSH,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic                  SS_N,
    output logic                  BUSY,
    output logic                  XFER_DONE
);

    localparam int EW = $clog2(2 * DATA_WIDTH);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

    state_t                state, state_nxt;
    logic [DIV_WIDTH-1:0]  div_cnt, clkdiv_q;
    logic [EW-1:0]         edge_cnt;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rx_data_q;
    logic [DATA_WIDTH-1:0] tx_shifted, rx_shifted;
    logic                  sclk_q, ss_n_q, busy_q;
    logic                  tx_pop, rx_push;
    logic                  start_ok, div_zero, leading;

    assign start_ok = EN && !TXFIFO_EMPTY;
    assign div_zero = (div_cnt == '0);
    assign leading  = !edge_cnt[0];

    // MOSI is taken straight from the TX register, so it is registered and
    // naturally returns to 0 once all bits have been shifted out.
`ifdef SPI_LSB_FIRST_EN
    assign MOSI       = tx_sr[0];
    assign tx_shifted = {1'b0, tx_sr[DATA_WIDTH-1:1]};
    assign rx_shifted = {MISO, rx_sr[DATA_WIDTH-1:1]};
`else
    assign MOSI       = tx_sr[DATA_WIDTH-1];
    assign tx_shifted = {tx_sr[DATA_WIDTH-2:0], 1'b0};
    assign rx_shifted = {rx_sr[DATA_WIDTH-2:0], MISO};
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_ok) state_nxt = LOAD;
            LOAD:  if (div_zero) state_nxt = SHIFT;
            SHIFT: if (div_zero && edge_cnt == LAST_EDGE) state_nxt = STORE;
            STORE: if (!RXFIFO_FULL) state_nxt = start_ok ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are gated by reset so nothing leaks out while PRESETn is low.
    always_comb begin
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        if (PRESETn) begin
            case (state)
                IDLE:  tx_pop = start_ok;
                STORE: begin
                    rx_push = !RXFIFO_FULL;
                    tx_pop  = !RXFIFO_FULL && start_ok;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            div_cnt   <= '0;
            clkdiv_q  <= '0;
            edge_cnt  <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else if (tx_pop) begin
            tx_sr    <= TX_DATA;
            div_cnt  <= CLKDIV;
            clkdiv_q <= CLKDIV;
            edge_cnt <= '0;
            sclk_q   <= CPOL;
            ss_n_q   <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            case (state)
                IDLE: sclk_q <= CPOL;
                LOAD: div_cnt <= div_zero ? clkdiv_q : div_cnt - 1'b1;
                SHIFT: begin
                    if (div_zero) begin
                        div_cnt  <= clkdiv_q;
                        sclk_q   <= ~sclk_q;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (leading) rx_sr <= rx_shifted;
                        else         tx_sr <= tx_shifted;
                        // Word is complete after the last leading edge; expose it for STORE.
                        if (edge_cnt == LAST_EDGE) rx_data_q <= rx_sr;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                STORE: if (rx_push) begin
                    ss_n_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign TX_POP    = tx_pop;
    assign RX_PUSH   = rx_push;
    assign XFER_DONE = rx_push;
    assign RX_DATA   = rx_data_q;
    assign SCLK      = sclk_q;
    assign SS_N      = ss_n_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: queue-modelled TX FIFO, scoreboard of expected RX words.
module tb_spi_xfer_ctrl;

    logic       PCLK, PRESETn, EN, CPOL, TXFIFO_EMPTY, TX_POP, RXFIFO_FULL, RX_PUSH;
    logic       SCLK, MOSI, MISO, SS_N, BUSY, XFER_DONE;
    logic [7:0] CLKDIV, TX_DATA, RX_DATA;
    logic       loop_en, miso_val;

`ifdef SPI_LSB_FIRST_EN
    localparam logic LSB_FIRST = 1'b1;
`else
    localparam logic LSB_FIRST = 1'b0;
`endif

    spi_xfer_ctrl #(.DATA_WIDTH(8), .DIV_WIDTH(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .EN(EN), .CPOL(CPOL), .CLKDIV(CLKDIV),
        .TXFIFO_EMPTY(TXFIFO_EMPTY), .TX_DATA(TX_DATA), .TX_POP(TX_POP),
        .RXFIFO_FULL(RXFIFO_FULL), .RX_DATA(RX_DATA), .RX_PUSH(RX_PUSH),
        .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS_N(SS_N), .BUSY(BUSY),
        .XFER_DONE(XFER_DONE)
    );

    assign MISO = loop_en ? MOSI : miso_val;

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    int checks = 0, failures = 0;
    int cyc = 0, pops = 0, pushes = 0, b2b = 0, rises = 0, rises_at_pop = 0, frame_rises = 0;
    int pop_cyc = -10, push_cyc = 0, prev_push_cyc = 0, ss_glitch = 0;
    logic first_mosi = 1'b0, sclk_prev = 1'b0, in_frame = 1'b0, pop_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        TXFIFO_EMPTY = (tx_q.size() == 0);
        TX_DATA      = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w, input logic [7:0] e);
        tx_q.push_back(w);
        exp_q.push_back(e);
        upd();
    endtask

    task automatic push_tx_only(input logic [7:0] w);
        tx_q.push_back(w);
        upd();
    endtask

    task automatic wait_pops(input int n, input int budget);
        int k = 0;
        while (pops < n && k < budget) begin tick(); k++; end
        chk("pop_timeout", pops, n);
    endtask

    task automatic wait_pushes(input int n, input int budget);
        int k = 0;
        while (pushes < n && k < budget) begin tick(); k++; end
        chk("push_timeout", pushes, n);
    endtask

    // FIFO pop takes effect after the edge on which the DUT latched the head word.
    always @(posedge PCLK) begin
        #1;
        if (pop_seen) begin
            if (tx_q.size() != 0) void'(tx_q.pop_front());
            pop_seen = 1'b0;
            upd();
        end
    end

    always @(negedge PCLK) begin
        cyc++;
        if (cyc == pop_cyc + 1) first_mosi = MOSI;
        if (SCLK && !sclk_prev) rises++;
        sclk_prev = SCLK;
        if (in_frame && SS_N) ss_glitch++;
        if (XFER_DONE || RX_PUSH) chk("xfer_done", XFER_DONE, RX_PUSH);
        if (RX_PUSH) begin
            chk("push_when_full", RXFIFO_FULL, 1'b0);
            chk("rx_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) chk("rx_data", RX_DATA, exp_q.pop_front());
            prev_push_cyc = push_cyc;
            push_cyc      = cyc;
            frame_rises   = rises - rises_at_pop;
            in_frame      = 1'b0;
            pushes++;
        end
        if (TX_POP) begin
            chk("pop_when_empty", TXFIFO_EMPTY, 1'b0);
            if (RX_PUSH) b2b++;
            pop_cyc      = cyc;
            rises_at_pop = rises;
            in_frame     = 1'b1;
            pop_seen     = 1'b1;
            pops++;
        end
    end

    initial begin
        int p, pb, b0;
        PRESETn = 1'b0; EN = 1'b0; CPOL = 1'b1; CLKDIV = 8'd1; RXFIFO_FULL = 1'b0;
        loop_en = 1'b1; miso_val = 1'b0;
        upd();
        repeat (2) tick();
        chk("rst_sclk", SCLK, 1'b0);
        chk("rst_ss_n", SS_N, 1'b1);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_strobes", {TX_POP, RX_PUSH, XFER_DONE}, 3'b000);
        chk("rst_rx_data", RX_DATA, 8'h00);
        PRESETn = 1'b1;
        #1 chk("sclk_before_edge", SCLK, 1'b0);
        tick();
        chk("sclk_idle_cpol1", SCLK, 1'b1);
        CPOL = 1'b0;
        tick();
        chk("sclk_idle_cpol0", SCLK, 1'b0);

        // Loopback single frame
        push_word(8'hA5, 8'hA5);
        EN = 1'b1;
        wait_pushes(1, 200);
        chk("lat_a5", push_cyc - pop_cyc, 35);
        chk("rises_a5", frame_rises, 8);
        chk("first_mosi_a5", first_mosi, 1'b1);
        repeat (2) tick();
        chk("idle_ss_n", SS_N, 1'b1);
        chk("idle_busy", BUSY, 1'b0);

        // Back-to-back, CPOL=1, MISO high
        EN = 1'b0; CPOL = 1'b1;
        push_word(8'h3C, 8'hFF);
        push_word(8'hC3, 8'hFF);
        repeat (2) tick();
        chk("sclk_idle_hi", SCLK, 1'b1);
        loop_en = 1'b0; miso_val = 1'b1;
        pb = pushes; b0 = b2b;
        EN = 1'b1;
        wait_pushes(pb + 2, 300);
        chk("b2b_pop", b2b - b0, 1);
        chk("b2b_period", push_cyc - prev_push_cyc, 35);
        repeat (2) tick();
        chk("sclk_idle_hi_after", SCLK, 1'b1);
        chk("ss_n_after_b2b", SS_N, 1'b1);
        chk("ss_n_between_frames", ss_glitch, 0);

        // RX FIFO full stall at STORE
        CPOL = 1'b0; loop_en = 1'b1; RXFIFO_FULL = 1'b1;
        b0 = pops; pb = pushes;
        push_word(8'h5A, 8'h5A);
        wait_pops(b0 + 1, 20);
        p = pop_cyc;
        for (int g = 0; g < 100 && cyc + 1 < p + 35; g++) tick();
        for (int i = 0; i < 10; i++) begin
            chk("stall_quiet", {RX_PUSH, SCLK, SS_N}, 3'b000);
            tick();
        end
        RXFIFO_FULL = 1'b0;
        wait_pushes(pb + 1, 20);
        chk("stall_lat", push_cyc - p, 45);

        // EN dropped during bit 3 with three words queued
        EN = 1'b0;
        push_word(8'h11, 8'h11);
        push_tx_only(8'h22);
        push_tx_only(8'h33);
        b0 = pops; pb = pushes;
        EN = 1'b1;
        wait_pops(b0 + 1, 20);
        p = pop_cyc;
        for (int g = 0; g < 100 && cyc + 1 < p + 16; g++) tick();
        EN = 1'b0;
        wait_pushes(pb + 1, 100);
        repeat (40) tick();
        chk("en_drop_pops", pops - b0, 1);
        chk("en_drop_left", tx_q.size(), 2);
        chk("en_drop_busy", BUSY, 1'b0);
        chk("en_drop_ss_n", SS_N, 1'b1);
        tx_q.delete();
        upd();

        // Reset mid-SHIFT
        CLKDIV = 8'd1;
        b0 = pops;
        push_tx_only(8'h96);
        EN = 1'b1;
        wait_pops(b0 + 1, 20);
        p = pop_cyc;
        for (int g = 0; g < 100 && cyc + 1 < p + 10; g++) tick();
        push_tx_only(8'h69);
        pb = pushes;
        PRESETn = 1'b0;
        #1;
        in_frame = 1'b0;
        chk("mid_rst_sclk_ss_mosi", {SCLK, SS_N, MOSI}, 3'b010);
        chk("mid_rst_busy", BUSY, 1'b0);
        chk("mid_rst_strobes", {TX_POP, RX_PUSH, XFER_DONE}, 3'b000);
        chk("mid_rst_rx_data", RX_DATA, 8'h00);
        repeat (3) tick();
        chk("mid_rst_no_push", pushes, pb);
        exp_q.push_back(8'h69);
        PRESETn = 1'b1;
        wait_pushes(pb + 1, 100);
        chk("post_rst_lat", push_cyc - pop_cyc, 35);

        // CLKDIV=0, bit-order probe, mid-frame CLKDIV change ignored
        EN = 1'b0;
        tick();
        CLKDIV = 8'd0;
        b0 = pops; pb = pushes;
        push_word(8'h01, 8'h01);
        EN = 1'b1;
        wait_pops(b0 + 1, 20);
        CLKDIV = 8'd3;
        wait_pushes(pb + 1, 100);
        chk("lat_div0", push_cyc - pop_cyc, 18);
        chk("rises_div0", frame_rises, 8);
        chk("first_mosi_01", first_mosi, LSB_FIRST);
        EN = 1'b0;
        repeat (3) tick();
        chk("final_busy", BUSY, 1'b0);
        chk("ss_n_glitch_total", ss_glitch, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
